// File: rtl/nto_accum_pkg.sv
// Shared constants, FSM state type and snapshot record for the nto statistics collector.
package nto_pkg;

  localparam int NTO_MAX  = 6;
  localparam int NTO_BAD  = 7;
  localparam int ACCW_MAX = 64;
  localparam int SUMW_MAX = 8;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } win_state_t;

  // Widest configuration; narrower instances zero-extend into it.
  typedef struct packed {
    logic [ACCW_MAX-1:0] total;
    logic [SUMW_MAX-1:0] min_sum;
    logic [SUMW_MAX-1:0] max_sum;
  } snap_t;

  function automatic int sumw(input int ndff);
    return $clog2(NTO_MAX * ndff + 1);
  endfunction

endpackage

// File: rtl/nto_accum_if.sv
// Sample bus and snapshot/read handshake between the DFF array, the collector and the host.
interface nto_accum_if #(
  parameter int NDFF = 8,
  parameter int ACCW = 32
);

  localparam int SUMW = nto_pkg::sumw(NDFF);

  logic [3*NDFF-1:0] nto_bus;
  logic              en;
  logic [15:0]       win_len;
  logic              rd_strobe;
  logic              snap_valid;
  logic [ACCW-1:0]   snap_total;
  logic [SUMW-1:0]   snap_min;
  logic [SUMW-1:0]   snap_max;
  logic [7:0]        ovr_cnt;
  logic              bad_nto;

  modport master (
    output nto_bus, en, win_len, rd_strobe,
    input  snap_valid, snap_total, snap_min, snap_max, ovr_cnt, bad_nto
  );

  modport slave (
    input  nto_bus, en, win_len, rd_strobe,
    output snap_valid, snap_total, snap_min, snap_max, ovr_cnt, bad_nto
  );

endinterface

// File: rtl/nto_adder_tree.sv
// Combinational clamp-and-sum of NDFF packed 3-bit nto fields; also flags any field equal to 7.
module nto_adder_tree
  import nto_pkg::*;
#(
  parameter int NDFF = 8,
  parameter int SUMW = sumw(8)
) (
  input  logic [3*NDFF-1:0] nto_bus,
  output logic [SUMW-1:0]   sum,
  output logic              any_bad
);

  always_comb begin
    sum     = '0;
    any_bad = 1'b0;
    for (int unsigned i = 0; i < NDFF; i++) begin
      if (nto_bus[3*i +: 3] == 3'(NTO_BAD)) begin
        any_bad = 1'b1;
        sum     = sum + SUMW'(NTO_MAX);
      end else begin
        sum = sum + SUMW'(nto_bus[3*i +: 3]);
      end
    end
  end

endmodule

// File: rtl/nto_accum.sv
// Windowed accumulator of per-cycle nto sums with min/max tracking and a host-read snapshot.
module nto_accum
  import nto_pkg::*;
#(
  parameter int NDFF = 8,
  parameter int ACCW = 32
) (
  input logic        U,
  input logic        _RESET,
  nto_accum_if.slave bus
);

  localparam int SUMW  = sumw(NDFF);
  localparam int ACCW1 = ACCW + 1;

  logic [SUMW-1:0] tree_sum;
  logic            tree_bad;

  logic [SUMW-1:0] cyc_sum;
  logic            en_d1;
  logic            bad_d1;

  win_state_t      state;
  logic [15:0]     len_q;
  logic [15:0]     cnt;
  logic [ACCW-1:0] acc;
  logic [SUMW-1:0] rmin;
  logic [SUMW-1:0] rmax;

  logic            snap_valid;
  logic [ACCW-1:0] snap_total;
  logic [SUMW-1:0] snap_min;
  logic [SUMW-1:0] snap_max;
  logic [7:0]      ovr_cnt;
  logic            bad_nto;

  nto_adder_tree #(
    .NDFF (NDFF),
    .SUMW (SUMW)
  ) u_tree (
    .nto_bus (bus.nto_bus),
    .sum     (tree_sum),
    .any_bad (tree_bad)
  );

  logic            start;
  logic            close;
  logic [15:0]     eff_len;
  logic [15:0]     cnt_base;
  logic [ACCW:0]   acc_wide;
  logic [ACCW-1:0] acc_nxt;
  logic [SUMW-1:0] min_nxt;
  logic [SUMW-1:0] max_nxt;

  // A window start folds the first sample in directly, so a length-1 window closes on it.
  always_comb begin
    start    = (state == ST_IDLE);
    eff_len  = start ? ((bus.win_len == '0) ? 16'd1 : bus.win_len) : len_q;
    cnt_base = start ? '0 : cnt;
    acc_wide = {1'b0, acc} + ACCW1'(cyc_sum);
    if (start) begin
      acc_nxt = ACCW'(cyc_sum);
      min_nxt = cyc_sum;
      max_nxt = cyc_sum;
    end else begin
      acc_nxt = acc_wide[ACCW] ? '1 : acc_wide[ACCW-1:0];
      min_nxt = (cyc_sum < rmin) ? cyc_sum : rmin;
      max_nxt = (cyc_sum > rmax) ? cyc_sum : rmax;
    end
    close = en_d1 && (({1'b0, cnt_base} + 17'd1) == {1'b0, eff_len});
  end

  always_ff @(posedge U) begin
    if (!_RESET) begin
      cyc_sum    <= '0;
      en_d1      <= 1'b0;
      bad_d1     <= 1'b0;
      state      <= ST_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      acc        <= '0;
      rmin       <= '0;
      rmax       <= '0;
      snap_valid <= 1'b0;
      snap_total <= '0;
      snap_min   <= '0;
      snap_max   <= '0;
      ovr_cnt    <= '0;
      bad_nto    <= 1'b0;
    end else begin
      cyc_sum <= tree_sum;
      en_d1   <= bus.en;
      bad_d1  <= tree_bad;

      if (en_d1) begin
        if (bad_d1) begin
          bad_nto <= 1'b1;
        end
        if (start) begin
          len_q <= eff_len;
        end
        if (close) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          state <= ST_RUN;
          cnt   <= cnt_base + 16'd1;
        end
        acc  <= acc_nxt;
        rmin <= min_nxt;
        rmax <= max_nxt;
      end

      // A strobe coinciding with a close frees the slot for the new result.
      if (close) begin
        if (!snap_valid || bus.rd_strobe) begin
          snap_valid <= 1'b1;
          snap_total <= acc_nxt;
          snap_min   <= min_nxt;
          snap_max   <= max_nxt;
        end else if (ovr_cnt != 8'hFF) begin
          ovr_cnt <= ovr_cnt + 8'd1;
        end
      end else if (bus.rd_strobe) begin
        snap_valid <= 1'b0;
      end
    end
  end

  assign bus.snap_valid = snap_valid;
  assign bus.snap_total = snap_total;
  assign bus.snap_min   = snap_min;
  assign bus.snap_max   = snap_max;
  assign bus.ovr_cnt    = ovr_cnt;
  assign bus.bad_nto    = bad_nto;

endmodule
